// File: rtl/word_packer_pkg.sv
// Shared types and width helpers for the word packer and its slot bank.
// Pure declarations; no latency or flow control of its own.
package word_packer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  // Width of a slot index into a DEPTH-slot bank.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Width of a word count that must reach DEPTH itself.
  function automatic int len_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/word_packer_slot_bank.sv
// DEPTH x WIDTH register bank, one write port decoded from wr_ptr, synchronous clear-all.
// Write visible one cycle after wr_en; no flow control, the caller gates wr_en.
module slot_bank
  import word_packer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [ptr_width(DEPTH)-1:0]   wr_ptr,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          clr,
  output logic [WIDTH*DEPTH-1:0]        frame_data
);

  localparam int PW = ptr_width(DEPTH);

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [WIDTH-1:0] slot_q;
    logic             slot_we;

    assign slot_we = wr_en && (wr_ptr == PW'(i));

    // Clear wins over write; the FSM never asserts both in one cycle anyway.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_q <= '0;
      end else if (clr) begin
        slot_q <= '0;
      end else if (slot_we) begin
        slot_q <= wr_data;
      end
    end

    assign frame_data[i*WIDTH +: WIDTH] = slot_q;
  end

endmodule

// File: rtl/word_packer.sv
// Packs a valid/ready word stream into a flattened DEPTH-slot frame; words land one cycle after accept.
// in_ready drops while a closed frame is held; frame stays frozen until frame_ready.
module word_packer
  import word_packer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_last,
  output logic [ptr_width(DEPTH)-1:0]   wr_ptr,
  output logic [WIDTH*DEPTH-1:0]        frame_data,
  output logic [len_width(DEPTH)-1:0]   frame_len,
  output logic                          frame_valid,
  input  logic                          frame_ready
);

  localparam int PW = ptr_width(DEPTH);
  localparam int LW = len_width(DEPTH);

  state_t state_q;
  state_t state_d;

  logic accept;
  logic last_slot;
  logic close;
  logic frame_take;

  // Handshake outputs come straight from the state register.
  assign in_ready    = (state_q == FILL);
  assign frame_valid = (state_q == FULL);

  assign accept     = in_valid && in_ready;
  assign last_slot  = (wr_ptr == PW'(DEPTH - 1));
  assign close      = accept && (in_last || last_slot);
  assign frame_take = frame_valid && frame_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FILL;
      FILL:    if (close) state_d = FULL;
      FULL:    if (frame_ready) state_d = FILL;
      default: state_d = IDLE;
    endcase
  end

  // The closing word leaves wr_ptr on its own slot so it never wraps mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      frame_len <= '0;
    end else if (frame_take) begin
      wr_ptr    <= '0;
      frame_len <= '0;
    end else if (accept) begin
      frame_len <= frame_len + LW'(1);
      if (!close) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
    end
  end

  slot_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_slot_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (accept),
    .wr_ptr     (wr_ptr),
    .wr_data    (in_data),
    .clr        (frame_take),
    .frame_data (frame_data)
  );

endmodule

// File: tb/tb_word_packer.sv
// Self-checking bench for word_packer: directed table, hand sequences, random traffic vs a queue model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_word_packer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int PW    = $clog2(DEPTH);
  localparam int LW    = PW + 1;
  localparam int FW    = WIDTH * DEPTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic [PW-1:0]    wr_ptr;
  logic [FW-1:0]    frame_data;
  logic [LW-1:0]    frame_len;
  logic             frame_valid;
  logic             frame_ready = 1'b0;

  word_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .wr_ptr      (wr_ptr),
    .frame_data  (frame_data),
    .frame_len   (frame_len),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: words of the open frame, whether it is closed and held, and the post-reset idle cycle.
  logic [WIDTH-1:0] cur[$];
  bit               held;
  bit               idle;

  typedef struct {
    logic             v;
    logic [WIDTH-1:0] d;
    logic             l;
    logic             fr;
    logic             e_rdy;
    logic             e_fv;
    logic [PW-1:0]    e_ptr;
    logic [LW-1:0]    e_len;
  } vec_t;

  vec_t          tbl[6];
  logic [FW-1:0] e_full;
  logic [FW-1:0] e_early;

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] model_frame();
    logic [FW-1:0] f;
    f = '0;
    foreach (cur[i]) f[i*WIDTH +: WIDTH] = cur[i];
    return f;
  endfunction

  task automatic model_reset();
    cur.delete();
    held = 1'b0;
    idle = 1'b1;
  endtask

  task automatic model_check();
    int n;
    n = cur.size();
    chk("in_ready",    FW'(in_ready),    FW'(!held && !idle));
    chk("frame_valid", FW'(frame_valid), FW'(held));
    chk("wr_ptr",      FW'(wr_ptr),      held ? FW'(n - 1) : FW'(n));
    chk("frame_len",   FW'(frame_len),   FW'(n));
    chk("frame_data",  frame_data,       model_frame());
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (idle) begin
      idle = 1'b0;
    end else if (held) begin
      if (frame_ready) begin
        cur.delete();
        held = 1'b0;
      end
    end else if (in_valid) begin
      cur.push_back(in_data);
      if (in_last || cur.size() == DEPTH) held = 1'b1;
    end
  endtask

  // Called on a falling edge: drive, take the rising edge, compare on the next falling edge.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic l, input logic fr);
    in_valid    = v;
    in_data     = d;
    in_last     = l;
    frame_ready = fr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 16'h000A, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 5'd1};
    tbl[1] = '{1'b0, 16'h0005, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 5'd1};
    tbl[2] = '{1'b1, 16'h000B, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 5'd2};
    tbl[3] = '{1'b1, 16'h000C, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 5'd3};
    tbl[4] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 5'd3};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 5'd0};

    e_early = '0;
    e_early[0*WIDTH +: WIDTH] = 16'h000A;
    e_early[1*WIDTH +: WIDTH] = 16'h000B;
    e_early[2*WIDTH +: WIDTH] = 16'h000C;
    e_full = '0;
    for (int i = 0; i < DEPTH; i++) e_full[i*WIDTH +: WIDTH] = WIDTH'(i);

    // Reset held with random inputs: everything reads zero.
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      step(1'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
    chk("reset_frame_data", frame_data, '0);
    rst_n = 1'b1;
    model_check();
    step(1'b1, 16'h5555, 1'b0, 1'b0);
    chk("ready_after_idle", FW'(in_ready), FW'(1));

    // Early last, ignored in_last, stray frame_ready, backpressure, release.
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].fr);
      chk("tbl_ready", FW'(in_ready),    FW'(tbl[i].e_rdy));
      chk("tbl_fv",    FW'(frame_valid), FW'(tbl[i].e_fv));
      chk("tbl_ptr",   FW'(wr_ptr),      FW'(tbl[i].e_ptr));
      chk("tbl_len",   FW'(frame_len),   FW'(tbl[i].e_len));
      if (i == 3) chk("early_frame", frame_data, e_early);
    end
    chk("early_cleared", frame_data, '0);

    // Full frame back-to-back.
    for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
    chk("full_fv",    FW'(frame_valid), FW'(1));
    chk("full_len",   FW'(frame_len),   FW'(DEPTH));
    chk("full_ptr",   FW'(wr_ptr),      FW'(DEPTH - 1));
    chk("full_rdy",   FW'(in_ready),    FW'(0));
    chk("full_frame", frame_data,       e_full);

    // Held frame ignores input while frame_ready stays low.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'hFFFF, 1'b0, 1'b0);
      chk("bp_frame", frame_data, e_full);
      chk("bp_len",   FW'(frame_len), FW'(DEPTH));
    end
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("take_fv",    FW'(frame_valid), FW'(0));
    chk("take_frame", frame_data,       '0);
    chk("take_ptr",   FW'(wr_ptr),      FW'(0));
    chk("take_rdy",   FW'(in_ready),    FW'(1));

    // Gapped input yields the same frame as back-to-back.
    for (int k = 0; k < 2 * DEPTH; k++) step(1'((k % 2) == 0), WIDTH'(k / 2), 1'b0, 1'b0);
    chk("gap_frame", frame_data, e_full);
    chk("gap_fv",    FW'(frame_valid), FW'(1));
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // Asynchronous reset mid-frame discards the partial frame.
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(16'h0100 + i), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    model_check();
    chk("midrst_frame", frame_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h7777, 1'b0, 1'b0);
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    chk("midrst_slot0", FW'(frame_data[WIDTH-1:0]), FW'(16'h1234));
    chk("midrst_ptr",   FW'(wr_ptr),               FW'(1));

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 99) < 70), WIDTH'($urandom),
           1'($urandom_range(0, 99) < 10), 1'($urandom_range(0, 99) < 40));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
